pwm_fade_ctrl: RTL and testbench

//  Bus-programmable fade sequencer that masters the pwm peripheral's register port.

---
 rtl/pwm_fade_ctrl_pkg.sv | 20 ++
 rtl/pwm_fade_ctrl_step.sv | 22 ++
 rtl/pwm_fade_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_fade_ctrl_pkg.sv
// Shared types and address-group constants for the pwm fade sequencer.
package pwm_fade_ctrl_pkg;

  typedef enum logic [1:0] {
    FADE_IDLE,
    FADE_WAIT,
    FADE_CALC,
    FADE_WRITE
  } fade_state_e;

  localparam logic [3:0] FADE_GRP_TARGET   = 4'h0;
  localparam logic [3:0] FADE_GRP_STEP     = 4'h1;
  localparam logic [3:0] FADE_GRP_CUR      = 4'h2;
  localparam logic [3:0] FADE_GRP_INTERVAL = 4'h3;
  localparam logic [3:0] FADE_GRP_CTRL     = 4'h4;
  localparam logic [3:0] FADE_GRP_STATUS   = 4'h5;

  localparam logic [3:0] PWM_GRP_B = 4'h1;

endpackage

// File: rtl/pwm_fade_ctrl_step.sv
// One fade step: moves cur toward target by step (0 counts as 1), never overshooting.
module pwm_fade_step (
  input  logic [31:0] cur,
  input  logic [31:0] target,
  input  logic [15:0] step,
  output logic [31:0] next_duty
);

  logic [31:0] step_eff;

  assign step_eff = (step == 16'h0) ? 32'd1 : {16'h0, step};

  always_comb begin
    next_duty = cur;
    if (target > cur) begin
      next_duty = ((target - cur) <= step_eff) ? target : cur + step_eff;
    end else if (cur > target) begin
      next_duty = ((cur - target) <= step_eff) ? target : cur - step_eff;
    end
  end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Fade sequencer mastering the pwm compare registers; define PWM_FADE_IRQ_EN
// to get the fade-complete interrupt (irq_o is tied low otherwise).
module pwm_fade_ctrl
  import pwm_fade_ctrl_pkg::*;
#(
  parameter int unsigned CHANNEL  = 4,
  parameter logic [31:0] PWM_BASE = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  output logic [31:0] data_o,
  output logic [31:0] pwm_data_o,
  output logic [31:0] pwm_addr_o,
  output logic        pwm_we_o,
  output logic        irq_o
);

  localparam int unsigned IDX_W = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;

  logic [31:0]      target_q [CHANNEL];
  logic [15:0]      step_q   [CHANNEL];
  logic [31:0]      cur_q    [CHANNEL];
  logic [31:0]      interval_q;
  logic             run_q;
  fade_state_e      state_q;
  logic [31:0]      cnt_q;
  logic [IDX_W-1:0] idx_q;

  logic [3:0]       grp;
  logic [3:0]       ch;
  logic             ch_ok;
  logic [IDX_W-1:0] ch_idx;
  logic [CHANNEL-1:0] busy;
  logic             cur_busy;
  logic             last_idx;
  logic [31:0]      next_duty;
  logic             unused_addr;

  assign grp         = addr_i[23:20];
  assign ch          = addr_i[19:16];
  assign ch_ok       = 32'(ch) < CHANNEL;
  assign ch_idx      = ch[IDX_W-1:0];
  assign cur_busy    = cur_q[idx_q] != target_q[idx_q];
  assign last_idx    = idx_q == IDX_W'(CHANNEL - 1);
  assign unused_addr = ^{addr_i[31:24], addr_i[15:0]};

  always_comb begin
    for (int i = 0; i < CHANNEL; i++) begin
      busy[i] = cur_q[i] != target_q[i];
    end
  end

  pwm_fade_step u_step (
    .cur       (cur_q[idx_q]),
    .target    (target_q[idx_q]),
    .step      (step_q[idx_q]),
    .next_duty (next_duty)
  );

  always_comb begin
    data_o = 32'h0;
    case (grp)
      FADE_GRP_TARGET:   if (ch_ok) data_o = target_q[ch_idx];
      FADE_GRP_STEP:     if (ch_ok) data_o = {16'h0, step_q[ch_idx]};
      FADE_GRP_CUR:      if (ch_ok) data_o = cur_q[ch_idx];
      FADE_GRP_INTERVAL: data_o = interval_q;
      FADE_GRP_CTRL:     data_o = {31'h0, run_q};
      FADE_GRP_STATUS: begin
        data_o[CHANNEL-1:0] = busy;
        data_o[31]          = state_q != FADE_IDLE;
      end
      default:           data_o = 32'h0;
    endcase
  end

  // CPU writes come after the FSM so a same-cycle CUR load overrides the fade update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < CHANNEL; i++) begin
        target_q[i] <= 32'h0;
        step_q[i]   <= 16'h0;
        cur_q[i]    <= 32'h0;
      end
      interval_q <= 32'h0;
      run_q      <= 1'b0;
      state_q    <= FADE_IDLE;
      cnt_q      <= 32'h0;
      idx_q      <= '0;
      pwm_we_o   <= 1'b0;
      pwm_data_o <= 32'h0;
      pwm_addr_o <= PWM_BASE;
    end else begin
      pwm_we_o <= 1'b0;
      case (state_q)
        FADE_IDLE: begin
          if (run_q) begin
            state_q <= FADE_WAIT;
            cnt_q   <= interval_q;
          end
        end
        FADE_WAIT: begin
          if (!run_q) begin
            state_q <= FADE_IDLE;
          end else if (cnt_q == 32'h0) begin
            state_q <= FADE_CALC;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        FADE_CALC: begin
          if (!run_q) begin
            state_q <= FADE_IDLE;
          end else if (cur_busy) begin
            cur_q[idx_q] <= next_duty;
            pwm_we_o     <= 1'b1;
            pwm_data_o   <= next_duty;
            pwm_addr_o   <= PWM_BASE | {8'h00, PWM_GRP_B, 4'(idx_q), 16'h0000};
            state_q      <= FADE_WRITE;
          end else if (last_idx) begin
            state_q <= FADE_WAIT;
            cnt_q   <= interval_q;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        FADE_WRITE: begin
          if (last_idx) begin
            state_q <= FADE_WAIT;
            cnt_q   <= interval_q;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= FADE_CALC;
          end
        end
        default: state_q <= FADE_IDLE;
      endcase

      if (we_i) begin
        case (grp)
          FADE_GRP_TARGET:   if (ch_ok) target_q[ch_idx] <= data_i;
          FADE_GRP_STEP:     if (ch_ok) step_q[ch_idx]   <= data_i[15:0];
          FADE_GRP_CUR:      if (ch_ok) cur_q[ch_idx]    <= data_i;
          FADE_GRP_INTERVAL: interval_q <= data_i;
          FADE_GRP_CTRL:     run_q      <= data_i[0];
          default: ;
        endcase
      end
    end
  end

`ifdef PWM_FADE_IRQ_EN
  logic irq_q;
  logic wrote_q;
  logic scan_end;

  // A scan ends on the last channel, either skipped in CALC or after its WRITE.
  assign scan_end = ((state_q == FADE_CALC) && run_q && !cur_busy && last_idx) ||
                    ((state_q == FADE_WRITE) && last_idx);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q   <= 1'b0;
      wrote_q <= 1'b0;
    end else begin
      irq_q <= scan_end && (busy == '0) && wrote_q;
      if (scan_end || ((state_q == FADE_WAIT) && (cnt_q == 32'h0))) begin
        wrote_q <= 1'b0;
      end else if ((state_q == FADE_CALC) && run_q && cur_busy) begin
        wrote_q <= 1'b1;
      end
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed self-checking bench for pwm_fade_ctrl (CHANNEL=4, non-zero PWM_BASE).
module tb_pwm_fade_ctrl;

  localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef PWM_FADE_IRQ_EN
  localparam int EXP_IRQ = 1;
`else
  localparam int EXP_IRQ = 0;
`endif

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } pwm_wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_i = '0;
  logic [31:0] addr_i = '0;
  logic        we_i = 1'b0;
  logic [31:0] data_o, pwm_data_o, pwm_addr_o;
  logic        pwm_we_o, irq_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int irq_cnt = 0;
  int irq_total = 0;
  pwm_wr_t wr_q[$];

  pwm_fade_ctrl #(.CHANNEL(4), .PWM_BASE(BASE)) dut (
    .clk_i(clk), .rst_i(rst), .data_i(data_i), .addr_i(addr_i), .we_i(we_i),
    .data_o(data_o), .pwm_data_o(pwm_data_o), .pwm_addr_o(pwm_addr_o),
    .pwm_we_o(pwm_we_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Log every pwm write and irq pulse away from the active edge.
  always @(negedge clk) begin
    if (pwm_we_o === 1'b1) wr_q.push_back('{cyc, pwm_addr_o, pwm_data_o});
    if (irq_o === 1'b1) begin
      irq_cnt++;
      irq_total++;
    end
  end

  task automatic cpu_write(input logic [3:0] grp, input logic [3:0] ch, input logic [31:0] d);
    @(negedge clk);
    addr_i = {8'h00, grp, ch, 16'h0000};
    data_i = d;
    we_i   = 1'b1;
    @(negedge clk);
    we_i   = 1'b0;
  endtask

  task automatic cpu_read(input logic [3:0] grp, input logic [3:0] ch, output logic [31:0] d);
    we_i   = 1'b0;
    addr_i = {8'h00, grp, ch, 16'h0000};
    #1 d = data_o;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    bit found = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (pwm_we_o !== 1'b0) begin n_err++; $display("[TB] FAIL rst_we: got %b want 0", pwm_we_o); end
    n_vec++; if (pwm_data_o !== 32'h0) begin n_err++; $display("[TB] FAIL rst_data: got %h want 0", pwm_data_o); end
    n_vec++; if (pwm_addr_o !== BASE) begin n_err++; $display("[TB] FAIL rst_addr: got %h want %h", pwm_addr_o, BASE); end
    n_vec++; if (irq_o !== 1'b0) begin n_err++; $display("[TB] FAIL rst_irq: got %b want 0", irq_o); end
    rst = 1'b0;
    cpu_read(4'h5, 4'h0, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("[TB] FAIL rst_status: got %h want 0", rd); end
    // Start a long fade, then reset in the middle of a WRITE.
    cpu_write(4'h0, 4'h0, 32'd100);
    cpu_write(4'h3, 4'h0, 32'd1);
    cpu_write(4'h4, 4'h0, 32'd1);
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (pwm_we_o === 1'b1) found = 1;
    end
    n_vec++; if (!found) begin n_err++; $display("[TB] FAIL midwrite_seen: got 0 want 1"); end
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (pwm_we_o !== 1'b0) begin n_err++; $display("[TB] FAIL midwrite_we: got %b want 0", pwm_we_o); end
    n_vec++; if (pwm_addr_o !== BASE) begin n_err++; $display("[TB] FAIL midwrite_addr: got %h want %h", pwm_addr_o, BASE); end
    rst = 1'b0;
    cpu_read(4'h5, 4'h0, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("[TB] FAIL midwrite_status: got %h want 0", rd); end
    cpu_read(4'h0, 4'h0, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("[TB] FAIL midwrite_target: got %h want 0", rd); end
    cpu_read(4'h2, 4'h0, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("[TB] FAIL midwrite_cur: got %h want 0", rd); end
    cpu_read(4'h3, 4'h0, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("[TB] FAIL midwrite_interval: got %h want 0", rd); end
    cpu_read(4'h4, 4'h0, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("[TB] FAIL midwrite_ctrl: got %h want 0", rd); end
  endtask

  task automatic test_cpu_map();
    logic [31:0] rd;
    cpu_write(4'h0, 4'h3, 32'hDEAD_BEEF);
    cpu_read(4'h0, 4'h3, rd);
    n_vec++; if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("[TB] FAIL map_target3: got %h want deadbeef", rd); end
    cpu_read(4'h5, 4'h0, rd);
    n_vec++; if (rd !== 32'h0000_0008) begin n_err++; $display("[TB] FAIL map_busy3: got %h want 8", rd); end
    cpu_write(4'h1, 4'h1, 32'hABCD_0007);
    cpu_read(4'h1, 4'h1, rd);
    n_vec++; if (rd !== 32'h0000_0007) begin n_err++; $display("[TB] FAIL map_step1: got %h want 7", rd); end
    cpu_write(4'h2, 4'h5, 32'h1234_5678);
    cpu_read(4'h2, 4'h5, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("[TB] FAIL map_badch: got %h want 0", rd); end
    cpu_write(4'h7, 4'h0, 32'hFFFF_FFFF);
    cpu_read(4'h7, 4'h0, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("[TB] FAIL map_unmapped: got %h want 0", rd); end
    cpu_write(4'h0, 4'h3, 32'h0);
    cpu_write(4'h1, 4'h1, 32'h0);
  endtask

  task automatic test_ramp_up();
    logic [31:0] exp_d [3] = '{32'd4, 32'd8, 32'd10};
    logic [31:0] rd, got_a, got_d;
    int sz;
    cpu_write(4'h0, 4'h0, 32'd10);
    cpu_write(4'h1, 4'h0, 32'd4);
    cpu_write(4'h3, 4'h0, 32'd3);
    wr_q.delete();
    cpu_write(4'h4, 4'h0, 32'd1);
    repeat (60) @(negedge clk);
    cpu_write(4'h4, 4'h0, 32'd0);
    repeat (3) @(negedge clk);
    sz = wr_q.size();
    n_vec++; if (sz !== 3) begin n_err++; $display("[TB] FAIL up_count: got %0d want 3", sz); end
    for (int i = 0; i < 3; i++) begin
      got_d = (i < sz) ? wr_q[i].data : 'x;
      got_a = (i < sz) ? wr_q[i].addr : 'x;
      n_vec++; if (got_d !== exp_d[i]) begin n_err++; $display("[TB] FAIL up_data%0d: got %h want %h", i, got_d, exp_d[i]); end
      n_vec++; if (got_a !== (BASE | 32'h0010_0000)) begin n_err++; $display("[TB] FAIL up_addr%0d: got %h want %h", i, got_a, BASE | 32'h0010_0000); end
    end
    for (int i = 1; i < 3; i++) begin
      int gap;
      gap = (i < sz) ? wr_q[i].cyc - wr_q[i-1].cyc : -1;
      n_vec++; if (gap !== 9) begin n_err++; $display("[TB] FAIL up_gap%0d: got %0d want 9", i, gap); end
    end
    cpu_read(4'h2, 4'h0, rd);
    n_vec++; if (rd !== 32'd10) begin n_err++; $display("[TB] FAIL up_cur: got %h want a", rd); end
    cpu_read(4'h5, 4'h0, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("[TB] FAIL up_status: got %h want 0", rd); end
  endtask

  task automatic test_ramp_down();
    logic [31:0] exp_d [2] = '{32'd2, 32'd0};
    logic [31:0] rd, got_a, got_d;
    int sz;
    cpu_write(4'h2, 4'h2, 32'd5);
    cpu_write(4'h1, 4'h2, 32'd3);
    cpu_write(4'h3, 4'h0, 32'd1);
    cpu_read(4'h5, 4'h0, rd);
    n_vec++; if (rd !== 32'h0000_0004) begin n_err++; $display("[TB] FAIL down_busy: got %h want 4", rd); end
    wr_q.delete();
    cpu_write(4'h4, 4'h0, 32'd1);
    repeat (40) @(negedge clk);
    cpu_write(4'h4, 4'h0, 32'd0);
    repeat (3) @(negedge clk);
    sz = wr_q.size();
    n_vec++; if (sz !== 2) begin n_err++; $display("[TB] FAIL down_count: got %0d want 2", sz); end
    for (int i = 0; i < 2; i++) begin
      got_d = (i < sz) ? wr_q[i].data : 'x;
      got_a = (i < sz) ? wr_q[i].addr : 'x;
      n_vec++; if (got_d !== exp_d[i]) begin n_err++; $display("[TB] FAIL down_data%0d: got %h want %h", i, got_d, exp_d[i]); end
      n_vec++; if (got_a !== (BASE | 32'h0012_0000)) begin n_err++; $display("[TB] FAIL down_addr%0d: got %h want %h", i, got_a, BASE | 32'h0012_0000); end
    end
    cpu_read(4'h5, 4'h0, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("[TB] FAIL down_status: got %h want 0", rd); end
  endtask

  task automatic test_skip_round_robin();
    logic [31:0] exp_d [4] = '{32'd3, 32'd19, 32'd6, 32'd18};
    logic [31:0] exp_a [4] = '{32'h0011_0000, 32'h0013_0000, 32'h0011_0000, 32'h0013_0000};
    int exp_gap [4] = '{0, 3, 4, 3};
    logic [31:0] got_a, got_d;
    int sz, gap;
    cpu_write(4'h0, 4'h1, 32'd6);
    cpu_write(4'h1, 4'h1, 32'd3);
    cpu_write(4'h2, 4'h3, 32'd20);
    cpu_write(4'h0, 4'h3, 32'd18);
    cpu_write(4'h1, 4'h3, 32'd0);
    cpu_write(4'h3, 4'h0, 32'd0);
    wr_q.delete();
    cpu_write(4'h4, 4'h0, 32'd1);
    repeat (40) @(negedge clk);
    cpu_write(4'h4, 4'h0, 32'd0);
    repeat (3) @(negedge clk);
    sz = wr_q.size();
    n_vec++; if (sz !== 4) begin n_err++; $display("[TB] FAIL rr_count: got %0d want 4", sz); end
    for (int i = 0; i < 4; i++) begin
      got_d = (i < sz) ? wr_q[i].data : 'x;
      got_a = (i < sz) ? wr_q[i].addr : 'x;
      n_vec++; if (got_d !== exp_d[i]) begin n_err++; $display("[TB] FAIL rr_data%0d: got %h want %h", i, got_d, exp_d[i]); end
      n_vec++; if (got_a !== (BASE | exp_a[i])) begin n_err++; $display("[TB] FAIL rr_addr%0d: got %h want %h", i, got_a, BASE | exp_a[i]); end
      if (i > 0) begin
        gap = (i < sz) ? wr_q[i].cyc - wr_q[i-1].cyc : -1;
        n_vec++; if (gap !== exp_gap[i]) begin n_err++; $display("[TB] FAIL rr_gap%0d: got %0d want %0d", i, gap, exp_gap[i]); end
      end
    end
  endtask

  task automatic test_stop_mid_scan();
    logic [31:0] rd;
    bit found = 0;
    int n0 = -1;
    cpu_write(4'h0, 4'h1, 32'd100);
    cpu_write(4'h1, 4'h1, 32'd1);
    cpu_write(4'h2, 4'h1, 32'd0);
    cpu_write(4'h0, 4'h2, 32'd100);
    cpu_write(4'h0, 4'h3, 32'd100);
    cpu_write(4'h2, 4'h3, 32'd0);
    cpu_write(4'h3, 4'h0, 32'd5);
    wr_q.delete();
    cpu_write(4'h4, 4'h0, 32'd1);
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (pwm_we_o === 1'b1 && pwm_addr_o === (BASE | 32'h0011_0000)) found = 1;
    end
    n_vec++; if (!found) begin n_err++; $display("[TB] FAIL stop_seen: got 0 want 1"); end
    addr_i = {8'h00, 4'h4, 4'h0, 16'h0000};
    data_i = 32'd0;
    we_i   = 1'b1;
    #1 n0 = wr_q.size();
    @(negedge clk);
    we_i = 1'b0;
    repeat (30) @(negedge clk);
    n_vec++; if (wr_q.size() !== 1 || n0 !== 1) begin n_err++; $display("[TB] FAIL stop_count: got %0d/%0d want 1/1", n0, wr_q.size()); end
    n_vec++; if (wr_q.size() < 1 || wr_q[0].data !== 32'd1) begin n_err++; $display("[TB] FAIL stop_ch1_data: got %0d entries want data 1", wr_q.size()); end
    cpu_read(4'h5, 4'h0, rd);
    n_vec++; if (rd[31] !== 1'b0) begin n_err++; $display("[TB] FAIL stop_fsm: got %b want 0", rd[31]); end
    cpu_read(4'h2, 4'h1, rd);
    n_vec++; if (rd !== 32'd1) begin n_err++; $display("[TB] FAIL stop_cur1: got %h want 1", rd); end
    cpu_read(4'h2, 4'h2, rd);
    n_vec++; if (rd !== 32'd0) begin n_err++; $display("[TB] FAIL stop_cur2: got %h want 0", rd); end
  endtask

  task automatic test_irq();
    logic [31:0] rd;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cpu_write(4'h0, 4'h0, 32'd2);
    cpu_write(4'h1, 4'h0, 32'd2);
    cpu_write(4'h0, 4'h1, 32'd3);
    cpu_write(4'h1, 4'h1, 32'd3);
    cpu_write(4'h3, 4'h0, 32'd2);
    wr_q.delete();
    irq_cnt = 0;
    cpu_write(4'h4, 4'h0, 32'd1);
    repeat (60) @(negedge clk);
    cpu_write(4'h4, 4'h0, 32'd0);
    repeat (3) @(negedge clk);
    n_vec++; if (irq_cnt !== EXP_IRQ) begin n_err++; $display("[TB] FAIL irq_pulses: got %0d want %0d", irq_cnt, EXP_IRQ); end
    n_vec++; if (wr_q.size() !== 2) begin n_err++; $display("[TB] FAIL irq_writes: got %0d want 2", wr_q.size()); end
    cpu_read(4'h5, 4'h0, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("[TB] FAIL irq_status: got %h want 0", rd); end
`ifndef PWM_FADE_IRQ_EN
    n_vec++; if (irq_total !== 0) begin n_err++; $display("[TB] FAIL irq_tied: got %0d pulses want 0", irq_total); end
`endif
  endtask

  initial begin
    test_reset();
    test_cpu_map();
    test_ramp_up();
    test_ramp_down();
    test_skip_round_robin();
    test_stop_mid_scan();
    test_irq();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
